vending_machine_param: RTL and testbench
========================================

# vending_machine_param

Parametrised successor to the two-product soda/diet vending controller. Supports `NUM_ITEMS` products, each with a per-item price and stock count. It accepts nickel, dime and quarter coins, including several in the same cycle, and caps credit. It also supports cancel/refund and pays change as one nickel pulse per cycle. It sits between the coin-acceptor/selection-panel inputs and the dispenser/coin-return actuators.

## Interface
- `NUM_ITEMS`, 2: number of products.
- `CREDIT_W`, 8: credit and price width, in cents.
- `PRICES`, {8'd45, 8'd45}: packed `NUM_ITEMS*CREDIT_W`. The price of item i is `PRICES[i*CREDIT_W +: CREDIT_W]`. Every price is a nonzero multiple of 5.
- `MAX_CREDIT`, 95: credit ceiling in cents. Must be a multiple of 5 and less than 2^CREDIT_W.
- `STOCK_W`, 4: per-item stock counter width.
- `STOCK_INIT`, 10: stock value after reset or restock.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `nickel / dime / quarter  in  1 each`: coin-present strobes worth 5/10/25 cents. Each is sampled for one cycle per coin.
- `select  in  NUM_ITEMS`: product request. The lowest set bit wins.
- `cancel  in  1`: refund request.
- `restock  in  NUM_ITEMS`: reload item i to `STOCK_INIT`.
- `give  out  NUM_ITEMS`: one-cycle dispense pulse.
- `deny  out  1`: one-cycle pulse when a select is refused.
- `coin_reject  out  1`: one-cycle pulse when a coin set is returned.
- `nickel_out  out  1`: change/refund pulse. Each asserted cycle returns 5 cents.
- `credit  out  CREDIT_W`: current credit.
- `busy  out  1`: high in VEND or CHANGE.

## Operation
- FSM states: IDLE, VEND, CHANGE. Reset puts the FSM in IDLE; `credit` = 0; every stock = `STOCK_INIT`; all outputs 0.
- Event priority in IDLE (one event per cycle):
  - `cancel`: if credit > 0, go to CHANGE (full refund). If credit = 0, no effect.
  - `select` nonzero: choose i = lowest set bit.
    - If credit ≥ price[i] and stock[i] > 0: credit −= price[i], stock[i] −= 1, go to VEND.
    - Otherwise: pulse `deny`; credit and stock are unchanged.
  - Coins: sum = 5·nickel + 10·dime + 25·quarter.
    - If credit + sum ≤ `MAX_CREDIT`: credit += sum.
    - Otherwise: the whole set is rejected with a `coin_reject` pulse and credit is unchanged.
- Coins presented in the same cycle as an accepted `cancel` or `select`, or while in VEND or CHANGE, are rejected with `coin_reject`.
- `select` and `cancel` are ignored outside IDLE (no `deny`).
- VEND lasts 1 cycle with `give[i]` high. It then goes to CHANGE if credit > 0, else IDLE.
- CHANGE: `nickel_out` = 1 on every CHANGE cycle, and credit −= 5 at each edge. Leave for IDLE on the edge where credit reaches 0.
- `restock[i]`: applied in any state; it takes priority over a same-cycle decrement of stock[i].
- Arithmetic:
  - The coin-sum compare uses `CREDIT_W+1` bits, so it cannot wrap.
  - Credit never underflows, because every price and every refund step is a multiple of 5.
- Asserting `rst` mid-vend or mid-change aborts immediately. Outstanding credit is forfeited.

## Timing
- All outputs are registered, except `nickel_out` and `busy`, which decode from the state register.
- Coin at edge n: `credit` is updated after edge n. `coin_reject` is high during cycle n+1.
- Select at edge n: VEND and `give` are high during cycle n+1. CHANGE begins at cycle n+2 and lasts credit/5 cycles.
- `deny` is high for the one cycle after the refused select.
- Cancel at edge n: `nickel_out` is high for cycles n+1 … n+credit/5.
- Full throughput: a new select is accepted on the first IDLE cycle after change completes.

## Structure
- Package `vending_pkg`: coin-value constants (5/10/25), `state_t` enum (IDLE/VEND/CHANGE), and the `NICKEL_STEP` constant.
- Sub-module `vending_stock`: one per item, via a generate loop. It holds a `STOCK_W` counter with `restock` load, a decrement on vend, and an `empty` flag.
- The top level holds the FSM, the credit register, the price mux and the priority encoder.

## Test plan
- Two quarters (credit 50), then `select`=01 → `give[0]` for 1 cycle, credit 5, 1 `nickel_out` pulse, IDLE with credit 0.
- quarter+dime+nickel in one cycle → credit 40. Then `select`=10 → `deny` pulse, credit stays 40. Then dime → credit 50.
- Credit 90 plus quarter → `coin_reject`, credit stays 90. Then nickel → credit 95. Then `select`=11 → `give[0]` only, change 50 = 10 pulses.
- Credit 35 plus `cancel` → exactly 7 consecutive `nickel_out` pulses, no `give`. Coins inserted during CHANGE are rejected.
- With `STOCK_INIT`=1: first vend of item 1 → `give[1]`; second vend of item 1 → `deny`. After `restock[1]`, vend of item 1 → `give[1]`.
- `rst` asserted in the 3rd CHANGE cycle → `nickel_out`, `busy` and `credit` go to 0 asynchronously, and the FSM is in IDLE when `rst` deasserts.

Source files
------------

// File: rtl/vending_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vending_pkg : coin values, FSM state encoding and refund step for the
//               parametrised vending controller.   rev 1.0
// ---------------------------------------------------------------------------
package vending_pkg;

  localparam int COIN_NICKEL  = 5;
  localparam int COIN_DIME    = 10;
  localparam int COIN_QUARTER = 25;
  localparam int NICKEL_STEP  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

endpackage : vending_pkg
`default_nettype wire

// File: rtl/vending_stock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vending_stock : per-item stock counter with restock load and vend decrement.
//                 rev 1.0
// ---------------------------------------------------------------------------
module vending_stock #(
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restock,
  input  logic i_dec,
  output logic o_empty
);

  logic [STOCK_W-1:0] r_count;

  // Restock wins over a same-cycle vend decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= STOCK_W'(STOCK_INIT);
    end else if (i_restock) begin
      r_count <= STOCK_W'(STOCK_INIT);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - STOCK_W'(1);
    end
  end

  assign o_empty = (r_count == '0);

endmodule : vending_stock
`default_nettype wire

// File: rtl/vending_machine_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vending_machine_param : N-item vending controller with coin capping,
//                         cancel/refund and nickel-per-cycle change.  rev 1.0
// ---------------------------------------------------------------------------
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int unsigned                       NUM_ITEMS  = 2,
  parameter int unsigned                       CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0]     PRICES     = {8'd45, 8'd45},
  parameter int unsigned                       MAX_CREDIT = 95,
  parameter int unsigned                       STOCK_W    = 4,
  parameter int unsigned                       STOCK_INIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_nickel,
  input  logic                 i_dime,
  input  logic                 i_quarter,
  input  logic [NUM_ITEMS-1:0] i_select,
  input  logic                 i_cancel,
  input  logic [NUM_ITEMS-1:0] i_restock,
  output logic [NUM_ITEMS-1:0] o_give,
  output logic                 o_deny,
  output logic                 o_coin_reject,
  output logic                 o_nickel_out,
  output logic [CREDIT_W-1:0]  o_credit,
  output logic                 o_busy
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CREDIT_W-1:0]   r_credit;
  logic [CREDIT_W-1:0]   w_credit_nxt;
  logic [NUM_ITEMS-1:0]  r_give;
  logic [NUM_ITEMS-1:0]  w_give_nxt;
  logic                  r_deny;
  logic                  w_deny_nxt;
  logic                  r_coin_reject;
  logic                  w_reject_nxt;
  logic                  w_vend;
  logic                  w_event;

  logic [NUM_ITEMS-1:0]  w_sel_1h;
  logic [NUM_ITEMS-1:0]  w_empty;
  logic [NUM_ITEMS-1:0]  w_dec;
  logic [CREDIT_W-1:0]   w_price;
  logic                  w_can_vend;
  logic                  w_coin_any;
  logic [CREDIT_W:0]     w_sum;
  logic [CREDIT_W:0]     w_total;
  logic                  w_coin_fits;

  // Isolate the lowest set select bit.
  assign w_sel_1h = i_select & (~i_select + NUM_ITEMS'(1));

  always_comb begin
    w_price = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      if (w_sel_1h[i]) begin
        w_price = w_price | PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign w_can_vend = (r_credit >= w_price) && (|(w_sel_1h & ~w_empty));

  assign w_coin_any  = i_nickel | i_dime | i_quarter;
  assign w_sum       = (i_nickel  ? (CREDIT_W+1)'(COIN_NICKEL)  : '0)
                     + (i_dime    ? (CREDIT_W+1)'(COIN_DIME)    : '0)
                     + (i_quarter ? (CREDIT_W+1)'(COIN_QUARTER) : '0);
  assign w_total     = {1'b0, r_credit} + w_sum;
  assign w_coin_fits = (w_total <= (CREDIT_W+1)'(MAX_CREDIT));

  genvar gi;
  generate
    for (gi = 0; gi < int'(NUM_ITEMS); gi++) begin : g_stock
      vending_stock #(
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
      ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .i_restock(i_restock[gi]),
        .i_dec    (w_dec[gi]),
        .o_empty  (w_empty[gi])
      );
    end
  endgenerate

  assign w_dec = w_vend ? w_sel_1h : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_give        <= '0;
      r_deny        <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_give        <= w_give_nxt;
      r_deny        <= w_deny_nxt;
      r_coin_reject <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_give_nxt   = '0;
    w_deny_nxt   = 1'b0;
    w_reject_nxt = 1'b0;
    w_vend       = 1'b0;
    w_event      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_cancel && (r_credit != '0)) begin
          w_event     = 1'b1;
          w_state_nxt = CHANGE;
        end else if (|i_select) begin
          if (w_can_vend) begin
            w_event      = 1'b1;
            w_vend       = 1'b1;
            w_credit_nxt = r_credit - w_price;
            w_give_nxt   = w_sel_1h;
            w_state_nxt  = VEND;
          end else begin
            w_deny_nxt = 1'b1;
          end
        end
        // Coins only land when no cancel/vend consumed this cycle.
        if (w_coin_any) begin
          if (!w_event && w_coin_fits) begin
            w_credit_nxt = w_total[CREDIT_W-1:0];
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      VEND: begin
        w_reject_nxt = w_coin_any;
        w_state_nxt  = (r_credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        w_reject_nxt = w_coin_any;
        if (r_credit <= CREDIT_W'(NICKEL_STEP)) begin
          w_credit_nxt = '0;
          w_state_nxt  = IDLE;
        end else begin
          w_credit_nxt = r_credit - CREDIT_W'(NICKEL_STEP);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_give        = r_give;
  assign o_deny        = r_deny;
  assign o_coin_reject = r_coin_reject;
  assign o_credit      = r_credit;
  assign o_nickel_out  = (r_state == CHANGE);
  assign o_busy        = (r_state != IDLE);

endmodule : vending_machine_param
`default_nettype wire

// File: tb/tb_vending_machine_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vending_machine_param : directed self-checking bench.   rev 1.0
// ---------------------------------------------------------------------------
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_nickel, i_dime, i_quarter, i_cancel;
  logic [1:0] i_select, i_restock;
  logic [1:0] o_give;
  logic       o_deny, o_coin_reject, o_nickel_out, o_busy;
  logic [7:0] o_credit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Item 0 costs 45, item 1 costs 50, one unit of stock each.
  vending_machine_param #(
    .NUM_ITEMS (2),
    .CREDIT_W  (8),
    .PRICES    ({8'd50, 8'd45}),
    .MAX_CREDIT(95),
    .STOCK_W   (4),
    .STOCK_INIT(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_nickel     (i_nickel),
    .i_dime       (i_dime),
    .i_quarter    (i_quarter),
    .i_select     (i_select),
    .i_cancel     (i_cancel),
    .i_restock    (i_restock),
    .o_give       (o_give),
    .o_deny       (o_deny),
    .o_coin_reject(o_coin_reject),
    .o_nickel_out (o_nickel_out),
    .o_credit     (o_credit),
    .o_busy       (o_busy)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coins(input logic n, input logic d, input logic q);
    i_nickel = n; i_dime = d; i_quarter = q;
    cycle();
    i_nickel = 0; i_dime = 0; i_quarter = 0;
  endtask

  task automatic press(input logic [1:0] sel);
    i_select = sel;
    cycle();
    i_select = 2'b00;
  endtask

  task automatic test_reset();
    total++; if (o_credit !== 8'd0) begin bad++; $display("FAIL reset_credit got=%0d exp=0", o_credit); end
    total++; if (o_give !== 2'b00) begin bad++; $display("FAIL reset_give got=%b exp=00", o_give); end
    total++; if ({o_deny, o_coin_reject, o_nickel_out, o_busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {o_deny, o_coin_reject, o_nickel_out, o_busy}); end
  endtask

  task automatic test_vend_with_change();
    put_coins(0, 0, 1);
    put_coins(0, 0, 1);
    total++; if (o_credit !== 8'd50) begin bad++; $display("FAIL t1_credit50 got=%0d exp=50", o_credit); end
    press(2'b01);
    total++; if (o_give !== 2'b01) begin bad++; $display("FAIL t1_give got=%b exp=01", o_give); end
    total++; if (o_credit !== 8'd5) begin bad++; $display("FAIL t1_credit5 got=%0d exp=5", o_credit); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL t1_busy_vend got=%b exp=1", o_busy); end
    cycle();
    total++; if ({o_give, o_nickel_out} !== 3'b001) begin
      bad++; $display("FAIL t1_change got=%b exp=001", {o_give, o_nickel_out}); end
    cycle();
    total++; if ({o_nickel_out, o_busy} !== 2'b00) begin
      bad++; $display("FAIL t1_idle got=%b exp=00", {o_nickel_out, o_busy}); end
    total++; if (o_credit !== 8'd0) begin bad++; $display("FAIL t1_credit0 got=%0d exp=0", o_credit); end
  endtask

  task automatic test_multi_coin_deny();
    put_coins(1, 1, 1);
    total++; if (o_credit !== 8'd40) begin bad++; $display("FAIL t2_credit40 got=%0d exp=40", o_credit); end
    press(2'b10);
    total++; if (o_deny !== 1'b1) begin bad++; $display("FAIL t2_deny got=%b exp=1", o_deny); end
    total++; if ({o_give, o_busy} !== 3'b000) begin bad++; $display("FAIL t2_nogive got=%b exp=000", {o_give, o_busy}); end
    total++; if (o_credit !== 8'd40) begin bad++; $display("FAIL t2_credit_kept got=%0d exp=40", o_credit); end
    cycle();
    total++; if (o_deny !== 1'b0) begin bad++; $display("FAIL t2_deny_pulse got=%b exp=0", o_deny); end
    put_coins(0, 1, 0);
    total++; if (o_credit !== 8'd50) begin bad++; $display("FAIL t2_credit50 got=%0d exp=50", o_credit); end
    press(2'b10);
    total++; if (o_give !== 2'b10) begin bad++; $display("FAIL t2_give1 got=%b exp=10", o_give); end
    total++; if (o_credit !== 8'd0) begin bad++; $display("FAIL t2_exact got=%0d exp=0", o_credit); end
    cycle();
    total++; if ({o_nickel_out, o_busy} !== 2'b00) begin
      bad++; $display("FAIL t2_no_change got=%b exp=00", {o_nickel_out, o_busy}); end
  endtask

  task automatic test_stock();
    put_coins(0, 0, 1);
    put_coins(0, 0, 1);
    press(2'b10);
    total++; if (o_deny !== 1'b1) begin bad++; $display("FAIL t5_empty_deny got=%b exp=1", o_deny); end
    total++; if (o_credit !== 8'd50) begin bad++; $display("FAIL t5_credit_kept got=%0d exp=50", o_credit); end
    i_restock = 2'b11;
    cycle();
    i_restock = 2'b00;
    press(2'b10);
    total++; if (o_give !== 2'b10) begin bad++; $display("FAIL t5_restock_give got=%b exp=10", o_give); end
    cycle();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t5_idle got=%b exp=0", o_busy); end
  endtask

  task automatic test_cap_and_priority();
    int pulses;
    put_coins(0, 0, 1);
    put_coins(0, 0, 1);
    put_coins(0, 0, 1);
    put_coins(0, 1, 0);
    put_coins(1, 0, 0);
    total++; if (o_credit !== 8'd90) begin bad++; $display("FAIL t3_credit90 got=%0d exp=90", o_credit); end
    put_coins(0, 0, 1);
    total++; if (o_coin_reject !== 1'b1) begin bad++; $display("FAIL t3_reject got=%b exp=1", o_coin_reject); end
    total++; if (o_credit !== 8'd90) begin bad++; $display("FAIL t3_credit_held got=%0d exp=90", o_credit); end
    put_coins(1, 0, 0);
    total++; if (o_coin_reject !== 1'b0) begin bad++; $display("FAIL t3_accept got=%b exp=0", o_coin_reject); end
    total++; if (o_credit !== 8'd95) begin bad++; $display("FAIL t3_credit95 got=%0d exp=95", o_credit); end
    press(2'b11);
    total++; if (o_give !== 2'b01) begin bad++; $display("FAIL t3_lowest_wins got=%b exp=01", o_give); end
    total++; if (o_credit !== 8'd50) begin bad++; $display("FAIL t3_credit_after got=%0d exp=50", o_credit); end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (o_nickel_out) pulses++;
    end
    total++; if (pulses !== 10) begin bad++; $display("FAIL t3_pulses got=%0d exp=10", pulses); end
    total++; if ({o_credit, o_busy} !== 9'd0) begin bad++; $display("FAIL t3_done got=%0d exp=0", {o_credit, o_busy}); end
  endtask

  task automatic test_cancel();
    int pulses, first, last, rejects;
    logic gave;
    put_coins(0, 1, 1);
    total++; if (o_credit !== 8'd35) begin bad++; $display("FAIL t4_credit35 got=%0d exp=35", o_credit); end
    i_cancel = 1;
    cycle();
    i_cancel = 0;
    pulses = 0; first = -1; last = -1; rejects = 0; gave = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_nickel_out) begin
        pulses++;
        if (first < 0) first = k;
        last = k;
      end
      if (o_give != 2'b00) gave = 1;
      if (o_coin_reject) rejects++;
      i_dime = (k == 2);
      cycle();
    end
    i_dime = 0;
    total++; if (pulses !== 7) begin bad++; $display("FAIL t4_pulses got=%0d exp=7", pulses); end
    total++; if (last - first + 1 !== 7) begin bad++; $display("FAIL t4_consecutive got=%0d exp=7", last - first + 1); end
    total++; if (first !== 0) begin bad++; $display("FAIL t4_start got=%0d exp=0", first); end
    total++; if (gave !== 1'b0) begin bad++; $display("FAIL t4_no_give got=%b exp=0", gave); end
    total++; if (rejects !== 1) begin bad++; $display("FAIL t4_coin_reject got=%0d exp=1", rejects); end
    total++; if (o_credit !== 8'd0) begin bad++; $display("FAIL t4_credit0 got=%0d exp=0", o_credit); end
  endtask

  task automatic test_reset_mid_change();
    put_coins(0, 1, 1);
    i_cancel = 1;
    cycle();
    i_cancel = 0;
    cycle();
    cycle();
    total++; if ({o_nickel_out, o_busy} !== 2'b11) begin
      bad++; $display("FAIL t6_in_change got=%b exp=11", {o_nickel_out, o_busy}); end
    rst = 1;
    #1;
    total++; if ({o_nickel_out, o_busy} !== 2'b00) begin
      bad++; $display("FAIL t6_async_flags got=%b exp=00", {o_nickel_out, o_busy}); end
    total++; if (o_credit !== 8'd0) begin bad++; $display("FAIL t6_async_credit got=%0d exp=0", o_credit); end
    #2;
    rst = 0;
    cycle();
    total++; if ({o_nickel_out, o_busy} !== 2'b00) begin
      bad++; $display("FAIL t6_idle got=%b exp=00", {o_nickel_out, o_busy}); end
    put_coins(1, 0, 0);
    total++; if (o_credit !== 8'd5) begin bad++; $display("FAIL t6_post_coin got=%0d exp=5", o_credit); end
  endtask

  initial begin
    rst = 1;
    i_nickel = 0; i_dime = 0; i_quarter = 0;
    i_select = 2'b00; i_cancel = 0; i_restock = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 0;
    cycle();
    test_vend_with_change();
    test_multi_coin_deny();
    test_stock();
    test_cap_and_priority();
    test_cancel();
    test_reset_mid_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vending_machine_param
`default_nettype wire
